mult_seq_ctrl: RTL
==================

// Module: mult_seq_ctrl
// PURPOSE
// - Sequencer for the multi-cycle shift-and-add multiplier datapath (5-reg file, Z bus, adder, shifter, ppgen).
// - Drives the datapath's control inputs: rd_enA/rd_enB/wr_en one-hot selects, unit enables, shift direction, done.
// - Also controls external operand loading.
// - Computes unsigned WIDTH x WIDTH -> 2*WIDTH products. Result is left in reg4 (accumulator) and presented on bus A during DONE.
// PARAMETERS
// - WIDTH  16  operand width; also the number of loop iterations
// - NREG   5   register-file size; width of the one-hot selects
// PORTS
// - clk         in   1     clock, all state changes on posedge
// - rst         in   1     synchronous, active-high reset
// - start       in   1     begin a multiply; sampled only in IDLE
// - rd_enA      out  NREG  one-hot read select, bus A (0 = none)
// - rd_enB      out  NREG  one-hot read select, bus B (0 = none)
// - wr_en       out  NREG  one-hot write select from Z (0 = none)
// - add_en      out  1     adder drives Z
// - shift_en    out  1     shifter drives Z
// - ppgen_en    out  1     partial-product generator drives Z
// - left_right  out  1     1 = shift left, 0 = shift right
// - ext_drv     out  1     top level drives Z with the operand chosen by ld_sel
// - ld_sel      out  2     0 = multiplicand, 1 = multiplier, 2 = const 1
// - busy        out  1     high in every state except IDLE
// - done        out  1     one-cycle pulse; product valid on A
// - err         out  1     one-cycle pulse on illegal state encoding
// BEHAVIOUR
// - Outputs are a Moore decode of the state and iteration counter only.
// - add_en, shift_en, ppgen_en and ext_drv are mutually exclusive; at most one is high in any cycle.
// - wr_en has at most one bit set.
// - Reset / IDLE: every output is 0 and the counter is 0.
// - rst has priority over all other inputs. Asserting it mid-operation returns the FSM to IDLE on that edge.
//   Register-file contents are then undefined, and no done pulse is produced.
// - IDLE  -> LD1 when start=1. Otherwise stay in IDLE.
// - LD1   ext_drv=1, ld_sel=0, wr_en=R1 -> LD2
// - LD2   ext_drv=1, ld_sel=1, wr_en=R2 -> LD5
// - LD5   ext_drv=1, ld_sel=2, wr_en=R5 -> CLR
// - CLR   A=R5, B=R5, shift_en=1, left_right=0, wr_en=R4. Computes 1>>1 = 0, which clears the accumulator. -> PP
// - PP    A=R1, B=R2, ppgen_en=1, wr_en=R3 -> ADD
// - ADD   A=R4, B=R3, add_en=1, wr_en=R4 -> SHL
// - SHL   A=R1, B=R5, shift_en=1, left_right=1, wr_en=R1 -> SHR
// - SHR   A=R2, B=R5, shift_en=1, left_right=0, wr_en=R2.
//   - If cnt == WIDTH-1: go to DONE and set cnt to 0.
//   - Otherwise: cnt++ and go to PP.
// - DONE  A=R4, done=1, busy=0 -> IDLE. A new start is accepted only from IDLE, on the next cycle.
// - Latency: 3 load + 1 clear + 4*WIDTH loop + 1 done cycles. For WIDTH=16, done is high exactly 69 cycles after the start edge.
// - start is ignored while busy, including start held high. A continuously held start restarts from IDLE once per 70 cycles.
// - Iteration counter is $clog2(WIDTH) bits and saturates at WIDTH-1. It never wraps mid-loop.
// - Illegal or unused state encoding: pulse err for one cycle, all other outputs 0, go to IDLE.
// - Arithmetic is 32-bit and unsigned. The multiplier is consumed LSB-first through ppgen (B[0]).
// STRUCTURE
// - mult_pkg holds: the state enum; one-hot register constants R1..R5 (R1=5'b00001 ... R5=5'b10000);
//   ld_sel codes; and the NREG localparam. The datapath shares this package.
// - One sub-module, mult_ctrl_decode: purely combinational (state, cnt) -> control word.
//   The top level holds only the state register, next-state logic and the iteration counter.
// TESTING
// - Bench pairs this block with the datapath and a behavioural operand driver.
// - 3 x 5 -> reg4 = 32'd15 on A in the cycle done=1; done exactly 69 cycles after start.
// - 16'hFFFF x 16'hFFFF -> 32'hFFFE0001. Also 0 x 16'h1234 -> 0, and 16'h8000 x 2 -> 32'h00010000.
// - start held high for 200 cycles -> done pulses at cycles 69, 139 and 209 after the first edge; never overlapping.
// - rst asserted during iteration 7, ADD state -> all outputs 0 next cycle, no done.
//   A fresh 7 x 9 afterwards returns 63.
// - start pulsed while busy at cycle 20 -> ignored: single done at 69, busy stays 1 throughout.
// - Assertion every cycle: enables mutually exclusive; rd_enA/rd_enB/wr_en one-hot or zero; err never fires in legal runs.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared types and constants for the shift-and-add multiplier
//             sequencer and its datapath (state encoding, register selects,
//             operand-load codes, control word layout).
//  Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

    localparam int NREG = 5;

    // One-hot register-file selects
    localparam logic [NREG-1:0] R1 = 5'b00001;  // multiplicand (shifted left)
    localparam logic [NREG-1:0] R2 = 5'b00010;  // multiplier (shifted right)
    localparam logic [NREG-1:0] R3 = 5'b00100;  // partial product
    localparam logic [NREG-1:0] R4 = 5'b01000;  // accumulator / result
    localparam logic [NREG-1:0] R5 = 5'b10000;  // constant 1

    // External operand selects driven onto Z by the top level
    localparam logic [1:0] LD_MCAND  = 2'd0;
    localparam logic [1:0] LD_MPLIER = 2'd1;
    localparam logic [1:0] LD_ONE    = 2'd2;

    // Sequencer states; codes 10..15 are illegal
    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_LD1  = 4'd1,
        S_LD2  = 4'd2,
        S_LD5  = 4'd3,
        S_CLR  = 4'd4,
        S_PP   = 4'd5,
        S_ADD  = 4'd6,
        S_SHL  = 4'd7,
        S_SHR  = 4'd8,
        S_DONE = 4'd9
    } state_t;

    // Full control word produced by the decoder
    typedef struct packed {
        logic [NREG-1:0] rd_en_a;
        logic [NREG-1:0] rd_en_b;
        logic [NREG-1:0] wr_en;
        logic            add_en;
        logic            shift_en;
        logic            ppgen_en;
        logic            left_right;
        logic            ext_drv;
        logic [1:0]      ld_sel;
        logic            busy;
        logic            done;
        logic            err;
        logic            last_iter;  // SHR of the final iteration
    } ctrl_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/mult_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mult_ctrl_decode
//  Purpose  : Combinational Moore decode of (state, iteration counter) into
//             the datapath control word. Illegal encodings raise err only.
//  Revision : 1.0  initial release
// ============================================================================
module mult_ctrl_decode
    import mult_pkg::*;
#(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  state_t           state,
    input  logic [CNT_W-1:0] cnt,
    output ctrl_t            ctrl
);

    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    // Control word per state; everything defaults to inactive
    always_comb begin
        ctrl = '0;
        case (state)
            S_IDLE: ;
            S_LD1: begin
                ctrl.busy    = 1'b1;
                ctrl.ext_drv = 1'b1;
                ctrl.ld_sel  = LD_MCAND;
                ctrl.wr_en   = R1;
            end
            S_LD2: begin
                ctrl.busy    = 1'b1;
                ctrl.ext_drv = 1'b1;
                ctrl.ld_sel  = LD_MPLIER;
                ctrl.wr_en   = R2;
            end
            S_LD5: begin
                ctrl.busy    = 1'b1;
                ctrl.ext_drv = 1'b1;
                ctrl.ld_sel  = LD_ONE;
                ctrl.wr_en   = R5;
            end
            S_CLR: begin
                // 1 >> 1 = 0 written into the accumulator
                ctrl.busy     = 1'b1;
                ctrl.rd_en_a  = R5;
                ctrl.rd_en_b  = R5;
                ctrl.shift_en = 1'b1;
                ctrl.wr_en    = R4;
            end
            S_PP: begin
                ctrl.busy     = 1'b1;
                ctrl.rd_en_a  = R1;
                ctrl.rd_en_b  = R2;
                ctrl.ppgen_en = 1'b1;
                ctrl.wr_en    = R3;
            end
            S_ADD: begin
                ctrl.busy    = 1'b1;
                ctrl.rd_en_a = R4;
                ctrl.rd_en_b = R3;
                ctrl.add_en  = 1'b1;
                ctrl.wr_en   = R4;
            end
            S_SHL: begin
                ctrl.busy       = 1'b1;
                ctrl.rd_en_a    = R1;
                ctrl.rd_en_b    = R5;
                ctrl.shift_en   = 1'b1;
                ctrl.left_right = 1'b1;
                ctrl.wr_en      = R1;
            end
            S_SHR: begin
                ctrl.busy      = 1'b1;
                ctrl.rd_en_a   = R2;
                ctrl.rd_en_b   = R5;
                ctrl.shift_en  = 1'b1;
                ctrl.wr_en     = R2;
                ctrl.last_iter = (cnt == C_CNT_LAST);
            end
            S_DONE: begin
                ctrl.rd_en_a = R4;
                ctrl.done    = 1'b1;
            end
            default: begin
                ctrl.err = 1'b1;
            end
        endcase
    end

endmodule : mult_ctrl_decode
`default_nettype wire

// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mult_seq_ctrl
//  Purpose  : Sequencer for the multi-cycle shift-and-add multiplier.
//             Holds the state register and iteration counter; the control
//             word is decoded by mult_ctrl_decode.
//  Revision : 1.0  initial release
// ============================================================================
module mult_seq_ctrl
    import mult_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [NREG-1:0] rd_enA,
    output logic [NREG-1:0] rd_enB,
    output logic [NREG-1:0] wr_en,
    output logic            add_en,
    output logic            shift_en,
    output logic            ppgen_en,
    output logic            left_right,
    output logic            ext_drv,
    output logic [1:0]      ld_sel,
    output logic            busy,
    output logic            done,
    output logic            err
);

    localparam int               CNT_W      = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    ctrl_t            w_ctrl;

    mult_ctrl_decode #(
        .WIDTH (WIDTH)
    ) u_decode (
        .state (r_state),
        .cnt   (r_cnt),
        .ctrl  (w_ctrl)
    );

    // State and iteration counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter update; illegal codes fall back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (start) w_state_nxt = S_LD1;
            end
            S_LD1:  w_state_nxt = S_LD2;
            S_LD2:  w_state_nxt = S_LD5;
            S_LD5:  w_state_nxt = S_CLR;
            S_CLR:  w_state_nxt = S_PP;
            S_PP:   w_state_nxt = S_ADD;
            S_ADD:  w_state_nxt = S_SHL;
            S_SHL:  w_state_nxt = S_SHR;
            S_SHR: begin
                if (w_ctrl.last_iter) begin
                    w_state_nxt = S_DONE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_state_nxt = S_PP;
                    // saturating increment keeps the counter from wrapping
                    w_cnt_nxt   = (r_cnt == C_CNT_LAST) ? r_cnt : r_cnt + 1'b1;
                end
            end
            S_DONE: w_state_nxt = S_IDLE;
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign rd_enA     = w_ctrl.rd_en_a;
    assign rd_enB     = w_ctrl.rd_en_b;
    assign wr_en      = w_ctrl.wr_en;
    assign add_en     = w_ctrl.add_en;
    assign shift_en   = w_ctrl.shift_en;
    assign ppgen_en   = w_ctrl.ppgen_en;
    assign left_right = w_ctrl.left_right;
    assign ext_drv    = w_ctrl.ext_drv;
    assign ld_sel     = w_ctrl.ld_sel;
    assign busy       = w_ctrl.busy;
    assign done       = w_ctrl.done;
    assign err        = w_ctrl.err;

endmodule : mult_seq_ctrl
`default_nettype wire
